led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 24, meaning the width of the dwell register and of the step counter.
REQ-002 SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port cfg_we, input, 1 bit: configuration write strobe, one write per cycle.
REQ-005 SHALL have port cfg_addr, input, 3 bits: configuration register select.
REQ-006 SHALL have port cfg_wdata, input, 32 bits: configuration write data.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to begin a sequence.
REQ-008 SHALL have port stop, input, 1 bit: single-cycle request to abort a sequence.
REQ-009 SHALL have port ledNum, output, 32 bits: LED code driven to the LED core's ledNumIn.
REQ-010 SHALL have port busy, output, 1 bit: high while a sequence runs.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a non-looping sequence completes.
REQ-012 SHALL have port step_idx, output, 2 bits: index of the current step.

Function
REQ-013 SHALL provide the following configuration registers, written when cfg_we=1:
- addr 0: DWELL = cfg_wdata[DWELL_W-1:0].
- addr 1: COUNT = cfg_wdata[2:0], the number of steps; 0 or a value >4 means 4.
- addr 2: LOOP = cfg_wdata[0].
- addr 4..7: PAT[addr-4] = cfg_wdata[3:0].
- addr 3: writes are ignored.
REQ-014 SHALL latch DWELL, COUNT and LOOP into working copies when a start is accepted; writes to them while busy SHALL NOT affect the running sequence.
REQ-015 SHALL read PAT entries live when each step is loaded, so PAT writes during a run take effect at the next step load.
REQ-016 SHALL implement FSM states IDLE and RUN.
REQ-017 IDLE: ledNum=0, busy=0, step_idx=0.
REQ-018 SHALL accept start in IDLE when stop=0. At that edge it SHALL enter RUN with ledNum={28'b0,PAT[0]}, step_idx=0 and counter=D-1, where D=max(DWELL,1).
REQ-019 In RUN, each edge with counter≠0 SHALL decrement the counter.
REQ-020 In RUN, each edge with counter=0 SHALL end the current step:
- Not the last step: step_idx+1, load that PAT entry, counter=D-1.
- Last step with LOOP=1: wrap to step_idx=0, load PAT[0], counter=D-1, no done pulse.
- Last step with LOOP=0: go to IDLE, ledNum=0, assert done for exactly the following cycle.
REQ-021 Each step SHALL therefore present its code on ledNum for exactly D cycles.
REQ-022 stop SHALL have priority over start and over step expiry. stop in RUN SHALL return to IDLE at that edge with ledNum=0 and no done pulse. stop in IDLE SHALL have no effect.
REQ-023 start while in RUN SHALL be ignored.
REQ-024 start and stop in the same IDLE cycle SHALL leave the block in IDLE.
REQ-025 A cfg write and a start in the same cycle SHALL latch the old register value; the new value applies to the next run.
REQ-026 ledNum[31:4] SHALL always be 0. PAT value 4'hF SHALL be passed unmodified; blanking that code is the LED core's job.
REQ-027 done SHALL be registered and never asserted simultaneously with busy=1.

Reset
REQ-028 rst=0 SHALL asynchronously force IDLE, ledNum=0, busy=0, done=0, step_idx=0, counter=0, DWELL=0, COUNT=0, LOOP=0 and PAT[0..3]=0.
REQ-029 Reset asserted mid-run SHALL abort the run without a done pulse. After release, the block SHALL wait in IDLE for a new start.

Verification
REQ-030 SHALL be covered: DWELL=3, COUNT=2, LOOP=0, PAT={1,2}, start -> ledNum 1 for 3 cycles, then 2 for 3 cycles, then 0; done high for 1 cycle; busy high for 6 cycles.
REQ-031 SHALL be covered: DWELL=0, COUNT=0, LOOP=1, PAT={1,2,4,8} -> ledNum cycles 1,2,4,8,1,... with one cycle per step; done never asserted.
REQ-032 SHALL be covered: a running sequence with stop at step 1 -> next cycle ledNum=0, busy=0, done=0; a second start in the same run is ignored.
REQ-033 SHALL be covered: DWELL rewritten from 5 to 2 while busy -> the current run keeps 5-cycle steps; the next run uses 2-cycle steps.
REQ-034 SHALL be covered: rst pulsed low mid-step -> outputs 0 immediately, no done; a start after release runs from step 0.
REQ-035 SHALL be covered: start and stop in the same cycle in IDLE -> busy stays 0, ledNum stays 0.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// LED sequence controller: steps through up to four 4-bit LED codes, each held
// for a configurable dwell time, with optional looping and stop/abort.
module led_seq_ctrl #(
  parameter int unsigned DWELL_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] ledNum,
  output logic        busy,
  output logic        done,
  output logic [1:0]  step_idx
);

  localparam int unsigned PAT_W  = 4;
  localparam int unsigned NSTEP  = 4;
  localparam int unsigned LED_W  = 32;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_CW = 3;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [DWELL_W-1:0]   dwell_r;
  logic [CNT_CW-1:0]    count_r;
  logic                 loop_r;
  logic [PAT_W-1:0]     pat_r [NSTEP];

  logic [DWELL_W-1:0]   dm1_w;
  logic [IDX_W-1:0]     last_w;
  logic                 loop_w;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;

  logic [DWELL_W-1:0]   dm1_cfg;
  logic [IDX_W-1:0]     last_cfg;
  logic [IDX_W-1:0]     idx_inc;
  logic                 latch;
  logic [LED_W-1:0]     led_d;
  logic                 busy_d, done_d;
  logic [IDX_W-1:0]     idx_d;
  logic                 unused_cfg;

  assign unused_cfg = ^cfg_wdata;

  // Configuration register file; address 3 is a hole.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_r <= '0;
      count_r <= '0;
      loop_r  <= 1'b0;
      for (int i = 0; i < NSTEP; i++) pat_r[i] <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        3'd0:    dwell_r <= cfg_wdata[DWELL_W-1:0];
        3'd1:    count_r <= cfg_wdata[CNT_CW-1:0];
        3'd2:    loop_r  <= cfg_wdata[0];
        3'd4, 3'd5, 3'd6, 3'd7:
                 pat_r[cfg_addr[IDX_W-1:0]] <= cfg_wdata[PAT_W-1:0];
        default: ;
      endcase
    end
  end

  // Decoded run parameters: counter reload (D-1) and index of the last step.
  assign dm1_cfg  = (dwell_r == '0) ? '0 : dwell_r - DWELL_W'(1);
  assign last_cfg = (count_r == '0 || count_r > CNT_CW'(NSTEP)) ?
                    IDX_W'(NSTEP - 1) : IDX_W'(count_r - CNT_CW'(1));
  assign idx_inc  = step_idx + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    led_d   = ledNum;
    busy_d  = busy;
    done_d  = 1'b0;
    idx_d   = step_idx;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        led_d  = '0;
        busy_d = 1'b0;
        idx_d  = '0;
        if (start && !stop) begin
          state_d = RUN;
          latch   = 1'b1;
          led_d   = LED_W'(pat_r[0]);
          busy_d  = 1'b1;
          cnt_d   = dm1_cfg;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          led_d   = '0;
          busy_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (step_idx != last_w) begin
          idx_d = idx_inc;
          led_d = LED_W'(pat_r[idx_inc]);
          cnt_d = dm1_w;
        end else if (loop_w) begin
          idx_d = '0;
          led_d = LED_W'(pat_r[0]);
          cnt_d = dm1_w;
        end else begin
          state_d = IDLE;
          led_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ledNum   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= '0;
      cnt_q    <= '0;
      dm1_w    <= '0;
      last_w   <= '0;
      loop_w   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ledNum   <= led_d;
      busy     <= busy_d;
      done     <= done_d;
      step_idx <= idx_d;
      cnt_q    <= cnt_d;
      if (latch) begin
        dm1_w  <= dm1_cfg;
        last_w <= last_cfg;
        loop_w <= loop_r;
      end
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: dwell timing, looping, stop, reset abort
// and configuration shadowing, checked against hand-computed values.
module tb_led_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        start;
  logic        stop;
  logic [31:0] ledNum;
  logic        busy;
  logic        done;
  logic [1:0]  step_idx;

  int n_tests = 0;
  int n_fail  = 0;

  led_seq_ctrl #(.DWELL_W(24)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .start    (start),
    .stop     (stop),
    .ledNum   (ledNum),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_led"},  ledNum,        32'd0);
    check({tag, "_busy"}, 32'(busy),     32'd0);
    check({tag, "_done"}, 32'(done),     32'(exp_done));
    check({tag, "_idx"},  32'(step_idx), 32'd0);
  endtask

  logic [31:0] pat4 [4];

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; stop = 1'b0;
    pat4[0] = 32'd1; pat4[1] = 32'd2; pat4[2] = 32'd4; pat4[3] = 32'd8;
    #12;
    check_idle("reset", 1'b0);
    rst = 1'b1;
    tick();

    // Two 3-cycle steps, no loop: 1,1,1,2,2,2 then done.
    cfg_write(3'd0, 32'd3);
    cfg_write(3'd1, 32'd2);
    cfg_write(3'd2, 32'd0);
    cfg_write(3'd4, 32'd1);
    cfg_write(3'd5, 32'd2);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      check("t1_led",  ledNum,        (i < 3) ? 32'd1 : 32'd2);
      check("t1_idx",  32'(step_idx), (i < 3) ? 32'd0 : 32'd1);
      check("t1_busy", 32'(busy),     32'd1);
      check("t1_done", 32'(done),     32'd0);
      tick();
    end
    check_idle("t1_end", 1'b1);
    tick();
    check_idle("t1_after", 1'b0);

    // Dwell 0 -> 1 cycle per step, count 0 -> 4 steps, looping.
    cfg_write(3'd0, 32'd0);
    cfg_write(3'd1, 32'd0);
    cfg_write(3'd2, 32'd1);
    for (int k = 0; k < 4; k++) cfg_write(3'(4 + k), pat4[k]);
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      check("t2_led",  ledNum,        pat4[i % 4]);
      check("t2_idx",  32'(step_idx), 32'(i % 4));
      check("t2_done", 32'(done),     32'd0);
      tick();
    end
    pulse_stop();
    check_idle("t2_stop", 1'b0);

    // Stop at step 1; a start in the middle of the run is ignored.
    cfg_write(3'd0, 32'd4);
    cfg_write(3'd1, 32'd3);
    cfg_write(3'd2, 32'd0);
    pulse_start();
    check("t3_led0", ledNum, 32'd1);
    tick();
    tick();
    pulse_start();
    check("t3_led_mid", ledNum,        32'd1);
    check("t3_idx_mid", 32'(step_idx), 32'd0);
    tick();
    check("t3_led1", ledNum,        32'd2);
    check("t3_idx1", 32'(step_idx), 32'd1);
    pulse_stop();
    check_idle("t3_stop", 1'b0);
    tick();
    check_idle("t3_after", 1'b0);

    // DWELL rewritten while busy only affects the next run.
    cfg_write(3'd0, 32'd5);
    cfg_write(3'd1, 32'd1);
    cfg_write(3'd4, 32'd3);
    pulse_start();
    check("t4_led_e0", ledNum, 32'd3);
    tick();
    cfg_write(3'd0, 32'd2);
    check("t4_led_e2", ledNum, 32'd3);
    tick();
    tick();
    check("t4_led_e4",  ledNum,    32'd3);
    check("t4_busy_e4", 32'(busy), 32'd1);
    tick();
    check_idle("t4_end", 1'b1);
    // Start together with a DWELL write: this run still uses 2.
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'd7;
    pulse_start();
    cfg_we = 1'b0; cfg_wdata = '0;
    check("t4b_led0", ledNum, 32'd3);
    tick();
    check("t4b_led1", ledNum, 32'd3);
    tick();
    check_idle("t4b_end", 1'b1);
    tick();
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      check("t4c_led", ledNum, 32'd3);
      tick();
    end
    check_idle("t4c_end", 1'b1);

    // Reset mid-step clears everything asynchronously; run restarts at step 0.
    cfg_write(3'd0, 32'd3);
    cfg_write(3'd1, 32'd2);
    pulse_start();
    tick();
    check("t5_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #2;
    check_idle("t5_rst", 1'b0);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("t5_wait", 1'b0);
    end
    cfg_write(3'd4, 32'hFFFF_FFFF);
    pulse_start();
    check("t5_led0", ledNum,        32'h0000_000F);
    check("t5_idx0", 32'(step_idx), 32'd0);
    check("t5_busy", 32'(busy),     32'd1);
    tick();
    check("t5_led1", ledNum,        32'd0);
    check("t5_idx1", 32'(step_idx), 32'd1);
    pulse_stop();
    check_idle("t5_stop", 1'b0);

    // start and stop together in IDLE keep the block idle.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_idle("t6_same", 1'b0);
    tick();
    check_idle("t6_after", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
